// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise, glitch-filter, deserialise and fold E0/F0/E1 prefixes into key events.
// Optional PS2RX_FIFO_EN adds a 4-entry event FIFO with key_ready handshake.
module ps2_kbd_rx #(
  parameter int unsigned FILTER  = 4,
  parameter int unsigned TIMEOUT = 2047
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_ext,
  output logic       key_pressed,
  output logic       frame_err,
  output logic [7:0] err_cnt
);

  localparam int unsigned FW = $clog2(FILTER + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  logic [1:0]    clk_sync;
  logic [1:0]    data_sync;
  logic          clk_s;
  logic          data_s;
  logic [FW-1:0] flt_cnt;
  logic          clk_flt;
  logic          fall;
  logic          fall_data;

  state_t        state;
  state_t        state_nxt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          par_bit;
  logic [TW-1:0] to_cnt;
  logic          to_hit;
  logic          fsm_err;
  logic          byte_ok;

  logic          byte_rdy;
  logic [7:0]    byte_q;
  logic          ext_flag;
  logic          brk_flag;
  logic [2:0]    skip;
  logic          ext_nxt;
  logic          brk_nxt;
  logic [2:0]    skip_nxt;
  logic          ev_valid;
  logic [7:0]    ev_code;
  logic          ev_ext;
  logic          ev_pressed;
  logic          drop;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      clk_sync  <= '1;
      data_sync <= '1;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // Filtered clock flips on the FILTER-th consecutive cycle of disagreement; the fall strobe is registered with its data sample.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      flt_cnt   <= '0;
      clk_flt   <= 1'b1;
      fall      <= 1'b0;
      fall_data <= 1'b1;
    end else begin
      fall      <= 1'b0;
      fall_data <= data_s;
      if (clk_s == clk_flt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FILTER - 1)) begin
        clk_flt <= clk_s;
        flt_cnt <= '0;
        fall    <= clk_flt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  assign to_hit = (to_cnt == TW'(TIMEOUT - 1));

  always_comb begin
    state_nxt = state;
    fsm_err   = 1'b0;
    byte_ok   = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          if (!fall_data) state_nxt = S_DATA;
          else            fsm_err   = 1'b1;
        end
      end
      S_DATA: begin
        if (fall && bit_cnt == 3'd7) state_nxt = S_PARITY;
      end
      S_PARITY: begin
        if (fall) state_nxt = S_STOP;
      end
      S_STOP: begin
        if (fall) begin
          state_nxt = S_IDLE;
          if (fall_data && (^{shift, par_bit})) byte_ok = 1'b1;
          else                                  fsm_err = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (state != S_IDLE && !fall && to_hit) begin
      state_nxt = S_IDLE;
      fsm_err   = 1'b1;
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      to_cnt   <= '0;
      byte_rdy <= 1'b0;
      byte_q   <= '0;
    end else begin
      state    <= state_nxt;
      byte_rdy <= byte_ok;
      if (byte_ok) byte_q <= shift;
      if (state == S_IDLE || fall) to_cnt <= '0;
      else if (!to_hit)            to_cnt <= to_cnt + 1'b1;
      if (fall) begin
        case (state)
          S_IDLE:   bit_cnt <= '0;
          S_DATA: begin
            shift   <= {fall_data, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
          end
          S_PARITY: par_bit <= fall_data;
          default:  ;
        endcase
      end
    end
  end

  always_comb begin
    ext_nxt    = ext_flag;
    brk_nxt    = brk_flag;
    skip_nxt   = skip;
    ev_valid   = 1'b0;
    ev_code    = byte_q;
    ev_ext     = ext_flag;
    ev_pressed = ~brk_flag;
    if (byte_rdy) begin
      if (skip != 3'd0) begin
        // Pause sequence: the remaining bytes are swallowed, the last one yields a single Pause make.
        skip_nxt = skip - 3'd1;
        if (skip == 3'd1) begin
          ev_valid   = 1'b1;
          ev_code    = 8'h77;
          ev_ext     = 1'b1;
          ev_pressed = 1'b1;
        end
      end else begin
        case (byte_q)
          8'hE0:   ext_nxt  = 1'b1;
          8'hF0:   brk_nxt  = 1'b1;
          8'hE1:   skip_nxt = 3'd7;
          default: begin
            ev_valid = 1'b1;
            ext_nxt  = 1'b0;
            brk_nxt  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      ext_flag <= 1'b0;
      brk_flag <= 1'b0;
      skip     <= '0;
    end else begin
      ext_flag <= ext_nxt;
      brk_flag <= brk_nxt;
      skip     <= skip_nxt;
    end
  end

`ifdef PS2RX_FIFO_EN
  logic [9:0] fifo_mem [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] fifo_cnt;
  logic       pop;
  logic       push;
  logic       full;

  assign full = (fifo_cnt == 3'd4);
  assign pop  = key_valid && key_ready;
  assign push = ev_valid && (!full || pop);
  assign drop = ev_valid && full && !pop;

  assign key_valid                        = (fifo_cnt != 3'd0);
  assign {key_ext, key_pressed, key_code} = fifo_mem[rd_ptr];

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < 4; i++) fifo_mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr] <= {ev_ext, ev_pressed, ev_code};
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: ;
      endcase
    end
  end
`else
  logic unused_key_ready;
  assign unused_key_ready = key_ready;
  assign drop             = 1'b0;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      key_valid   <= 1'b0;
      key_code    <= '0;
      key_ext     <= 1'b0;
      key_pressed <= 1'b0;
    end else begin
      key_valid <= ev_valid;
      if (ev_valid) begin
        key_code    <= ev_code;
        key_ext     <= ev_ext;
        key_pressed <= ev_pressed;
      end
    end
  end
`endif

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      frame_err <= 1'b0;
      err_cnt   <= '0;
    end else begin
      frame_err <= fsm_err | drop;
      if ((fsm_err | drop) && err_cnt != 8'hFF) err_cnt <= err_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ps2_kbd_rx.sv
// Directed bench for ps2_kbd_rx: table of key sequences plus hand-written error, timeout, glitch, FIFO and reset cases.
module tb_ps2_kbd_rx;

  logic       clk_sys = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_ready;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ext;
  logic       key_pressed;
  logic       frame_err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;

  int         ev_cnt = 0;
  int         fe_cnt = 0;
  logic [7:0] last_code = '0;
  logic       last_ext = 1'b0;
  logic       last_pr = 1'b0;
  int         exp_err = 0;

  ps2_kbd_rx #(.FILTER(4), .TIMEOUT(2047)) dut (
    .clk_sys    (clk_sys),
    .reset_n    (reset_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .key_ready  (key_ready),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ext    (key_ext),
    .key_pressed(key_pressed),
    .frame_err  (frame_err),
    .err_cnt    (err_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  initial begin
    #(10 * 150000);
    $display("FAIL watchdog: simulation did not finish within bound");
    $fatal(1);
  end

  // Event monitor: an event is a key_valid cycle that the consumer accepts.
  always @(negedge clk_sys) begin
    if (reset_n) begin
`ifdef PS2RX_FIFO_EN
      if (key_valid && key_ready) begin
`else
      if (key_valid) begin
`endif
        ev_cnt    = ev_cnt + 1;
        last_code = key_code;
        last_ext  = key_ext;
        last_pr   = key_pressed;
      end
      if (frame_err) fe_cnt = fe_cnt + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic ps2_bit(input logic b, input bit glitch);
    ps2_clk = 1'b1;
    cyc(20);
    if (glitch) begin
      ps2_clk = 1'b0; cyc(1); ps2_clk = 1'b1;
    end
    cyc(30);
    ps2_data = b;
    cyc(50);
    ps2_clk = 1'b0;
    cyc(50);
    if (glitch) begin
      ps2_clk = 1'b1; cyc(2); ps2_clk = 1'b0;
    end
    cyc(50);
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit glitch);
    ps2_bit(1'b0, glitch);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], glitch);
    ps2_bit((~^b) ^ bad_par, glitch);
    ps2_bit(1'b1, glitch);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
    cyc(60);
  endtask

  task automatic send_partial(input logic [7:0] b, input int nbits);
    ps2_bit(1'b0, 1'b0);
    for (int i = 0; i < nbits; i++) ps2_bit(b[i], 1'b0);
    ps2_clk  = 1'b1;
    ps2_data = 1'b1;
  endtask

  task automatic expect_event(input string name, input int ev0, input int fe0,
                              input logic [7:0] code, input logic ext, input logic pr);
    #1;
    chk({name, "_events"}, ev_cnt - ev0, 1);
    chk({name, "_code"}, last_code, code);
    chk({name, "_ext"}, last_ext, ext);
    chk({name, "_pressed"}, last_pr, pr);
    chk({name, "_frame_err"}, fe_cnt - fe0, 0);
    chk({name, "_err_cnt"}, err_cnt, exp_err);
  endtask

  typedef struct {
    logic [63:0] bytes;
    int          n;
    bit          glitch;
    logic [7:0]  code;
    logic        ext;
    logic        pr;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int   ev0;
    int   fe0;
    logic [63:0] bb;
    logic [7:0]  b;

    vecs[0] = '{64'h1C,               1, 1'b0, 8'h1C, 1'b0, 1'b1};
    vecs[1] = '{64'h1CF0,             2, 1'b0, 8'h1C, 1'b0, 1'b0};
    vecs[2] = '{64'h75F0E0,           3, 1'b0, 8'h75, 1'b1, 1'b0};
    vecs[3] = '{64'h1CE0,             2, 1'b0, 8'h1C, 1'b1, 1'b1};
    vecs[4] = '{64'hAA,               1, 1'b0, 8'hAA, 1'b0, 1'b1};
    vecs[5] = '{64'h77F014F0E17714E1, 8, 1'b1, 8'h77, 1'b1, 1'b1};
    vecs[6] = '{64'h6BE0,             2, 1'b1, 8'h6B, 1'b1, 1'b1};

`ifdef PS2RX_FIFO_EN
    key_ready = 1'b1;
`else
    key_ready = 1'b0;
`endif

    cyc(5);
    chk("rst_key_valid", key_valid, 0);
    chk("rst_key_code", key_code, 0);
    chk("rst_key_ext", key_ext, 0);
    chk("rst_key_pressed", key_pressed, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_err_cnt", err_cnt, 0);
    reset_n = 1'b1;
    cyc(20);

    for (int i = 0; i < 7; i++) begin
      ev0 = ev_cnt;
      fe0 = fe_cnt;
      bb  = vecs[i].bytes;
      for (int j = 0; j < vecs[i].n; j++) begin
        b = bb[8*j +: 8];
        send_frame(b, 1'b0, vecs[i].glitch);
      end
      expect_event($sformatf("vec%0d", i), ev0, fe0, vecs[i].code, vecs[i].ext, vecs[i].pr);
    end

    // Bad parity: error only, then a good byte decodes.
    ev0 = ev_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b1, 1'b0);
    exp_err++;
    #1;
    chk("badpar_events", ev_cnt - ev0, 0);
    chk("badpar_frame_err", fe_cnt - fe0, 1);
    chk("badpar_err_cnt", err_cnt, exp_err);
    ev0 = ev_cnt; fe0 = fe_cnt;
    send_frame(8'h32, 1'b0, 1'b0);
    expect_event("after_badpar", ev0, fe0, 8'h32, 1'b0, 1'b1);

    // A fall with data high while idle is not a start bit.
    ev0 = ev_cnt; fe0 = fe_cnt;
    ps2_bit(1'b1, 1'b0);
    ps2_clk = 1'b1;
    cyc(60);
    exp_err++;
    #1;
    chk("idle_hi_events", ev_cnt - ev0, 0);
    chk("idle_hi_frame_err", fe_cnt - fe0, 1);
    chk("idle_hi_err_cnt", err_cnt, exp_err);

    // Timeout after 5 data bits; the E0 sent before it must survive.
    send_frame(8'hE0, 1'b0, 1'b0);
    ev0 = ev_cnt; fe0 = fe_cnt;
    send_partial(8'h55, 5);
    cyc(3000);
    exp_err++;
    #1;
    chk("timeout_events", ev_cnt - ev0, 0);
    chk("timeout_frame_err", fe_cnt - fe0, 1);
    chk("timeout_err_cnt", err_cnt, exp_err);
    ev0 = ev_cnt; fe0 = fe_cnt;
    send_frame(8'h29, 1'b0, 1'b0);
    expect_event("after_timeout", ev0, fe0, 8'h29, 1'b1, 1'b1);

`ifdef PS2RX_FIFO_EN
    key_ready = 1'b0;
    ev0 = ev_cnt; fe0 = fe_cnt;
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0, 1'b0);
    exp_err++;
    #1;
    chk("fifo_drop_frame_err", fe_cnt - fe0, 1);
    chk("fifo_drop_err_cnt", err_cnt, exp_err);
    for (int i = 1; i <= 4; i++) begin
      cyc(1);
      chk($sformatf("fifo_valid%0d", i), key_valid, 1);
      chk($sformatf("fifo_code%0d", i), key_code, i);
      chk($sformatf("fifo_ext%0d", i), key_ext, 0);
      chk($sformatf("fifo_pr%0d", i), key_pressed, 1);
      key_ready = 1'b1;
      cyc(1);
      key_ready = 1'b0;
    end
    cyc(2);
    chk("fifo_empty_valid", key_valid, 0);
    chk("fifo_pop_events", ev_cnt - ev0, 4);
    key_ready = 1'b1;
`endif

    // Reset mid-frame with an E0 pending: everything is discarded.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_partial(8'hFF, 3);
    cyc(5);
    reset_n = 1'b0;
    cyc(5);
    chk("midrst_key_valid", key_valid, 0);
    chk("midrst_key_code", key_code, 0);
    chk("midrst_key_ext", key_ext, 0);
    chk("midrst_err_cnt", err_cnt, 0);
    reset_n = 1'b1;
    exp_err = 0;
    cyc(20);
    ev0 = ev_cnt; fe0 = fe_cnt;
    send_frame(8'h1C, 1'b0, 1'b0);
    expect_event("after_midrst", ev0, fe0, 8'h1C, 1'b0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
